// File: rtl/srpt_pkg.sv
// Shared widths, SRPT_DATA field ranges and the per-message slot record for the
// Homa outbound data-packet scheduler.
package srpt_pkg;
   localparam int SRPT_DATA_SIZE   = 106;
   localparam int GRANT_SIZE       = 42;
   localparam int DBUFF_SIZE       = 42;
   localparam int PKT_SIZE_DEFAULT = 1024;
   localparam int CREDIT_W         = 32;

   localparam int DBUFF_ID_LO  = 0;
   localparam int DBUFF_ID_HI  = 9;
   localparam int REMAINING_LO = 10;
   localparam int REMAINING_HI = 41;
   localparam int GRANTED_LO   = 42;
   localparam int GRANTED_HI   = 73;
   localparam int DBUFFERED_LO = 74;
   localparam int DBUFFERED_HI = 105;

   // grant and dbuff words share one layout: {credit[41:10], dbuff_id[9:0]}
   localparam int CREDIT_LO = 10;
   localparam int CREDIT_HI = 41;

   typedef struct packed {
      logic                valid;
      logic [9:0]          dbuff_id;
      logic [CREDIT_W-1:0] remaining;
      logic [CREDIT_W-1:0] granted;
      logic [CREDIT_W-1:0] dbuffered;
   } slot_t;

   function automatic logic [CREDIT_W-1:0] sat_add32(input logic [CREDIT_W-1:0] a,
                                                      input logic [CREDIT_W-1:0] b);
      logic [CREDIT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
   endfunction
endpackage

// File: rtl/srpt_min_select.sv
// Combinational argmin over (remaining, eligible) pairs; ties resolve to the
// lowest index.
module srpt_min_select
   import srpt_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic [DEPTH-1:0][CREDIT_W-1:0] remaining,
   input  logic [DEPTH-1:0]               eligible,
   output logic [IDX_W-1:0]               idx,
   output logic                           found
);
   logic [CREDIT_W-1:0] best;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      best  = '1;
      // strict less-than keeps the earlier slot on equal remaining
      for (int i = 0; i < DEPTH; i++) begin
         if (eligible[i] && (!found || (remaining[i] < best))) begin
            found = 1'b1;
            best  = remaining[i];
            idx   = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/srpt_data_pkt_queue.sv
// SRPT scheduler for outbound Homa data packets: one descriptor per cycle for the
// eligible message with fewest remaining bytes. Grant credit path: SRPT_DATA_GRANT_EN.
module srpt_data_pkt_queue
   import srpt_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int PKT_SIZE = PKT_SIZE_DEFAULT
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      ap_ce,
   input  logic                      ap_start,
   input  logic                      ap_continue,
   output logic                      ap_idle,
   output logic                      ap_done,
   output logic                      ap_ready,
   input  logic                      sendmsg_in_empty_i,
   output logic                      sendmsg_in_read_en_o,
   input  logic [SRPT_DATA_SIZE-1:0] sendmsg_in_data_i,
   input  logic                      grant_in_empty_i,
   output logic                      grant_in_read_en_o,
   input  logic [GRANT_SIZE-1:0]     grant_in_data_i,
   input  logic                      dbuff_in_empty_i,
   output logic                      dbuff_in_read_en_o,
   input  logic [DBUFF_SIZE-1:0]     dbuff_in_data_i,
   input  logic                      data_pkt_full_i,
   output logic                      data_pkt_write_en_o,
   output logic [SRPT_DATA_SIZE-1:0] data_pkt_data_o
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CREDIT_W-1:0] PKT_N = CREDIT_W'(PKT_SIZE);

   slot_t                         slots_reg  [DEPTH];
   slot_t                         slots_next [DEPTH];
   slot_t                         sel_slot;
   logic [DEPTH-1:0][CREDIT_W-1:0] rem_vec;
   logic [DEPTH-1:0]              elig_vec;
   logic [IDX_W-1:0]              sel_idx, free_idx, hit_idx;
   logic                          sel_found, free_found, hit_found, any_valid;
   logic                          run, emit, credit_rd, credit_is_grant, grant_quiet;
   logic [9:0]                    credit_id;
   logic [CREDIT_W-1:0]           credit_add;

   assign run = ap_ce & ap_start;

`ifdef SRPT_DATA_GRANT_EN
   assign grant_in_read_en_o = run & ~grant_in_empty_i;
   assign grant_quiet        = grant_in_empty_i;
`else
   logic unused_grant;
   assign grant_in_read_en_o = 1'b0;
   assign grant_quiet        = 1'b1;
   assign unused_grant       = grant_in_empty_i;
`endif

   assign dbuff_in_read_en_o   = run & ~dbuff_in_empty_i & ~grant_in_read_en_o;
   assign credit_rd            = grant_in_read_en_o | dbuff_in_read_en_o;
   assign credit_is_grant      = grant_in_read_en_o;
   assign credit_id            = credit_is_grant ? grant_in_data_i[DBUFF_ID_HI:DBUFF_ID_LO]
                                                 : dbuff_in_data_i[DBUFF_ID_HI:DBUFF_ID_LO];
   assign credit_add           = credit_is_grant ? grant_in_data_i[CREDIT_HI:CREDIT_LO]
                                                 : dbuff_in_data_i[CREDIT_HI:CREDIT_LO];
   assign sendmsg_in_read_en_o = run & ~sendmsg_in_empty_i & ~credit_rd & free_found;

   // lowest free slot for new messages, lowest matching valid slot for credit
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      hit_found  = 1'b0;
      hit_idx    = '0;
      any_valid  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!slots_reg[i].valid) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (slots_reg[i].valid && (slots_reg[i].dbuff_id == credit_id)) begin
            hit_found = 1'b1;
            hit_idx   = IDX_W'(i);
         end
         any_valid = any_valid | slots_reg[i].valid;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      slot_t               s;
      slot_t               nx;
      logic [CREDIT_W-1:0] n;

      assign s           = slots_reg[gi];
      assign n           = (s.remaining < PKT_N) ? s.remaining : PKT_N;
      assign rem_vec[gi] = s.remaining;
`ifdef SRPT_DATA_GRANT_EN
      assign elig_vec[gi] = s.valid & (s.granted >= n) & (s.dbuffered >= n);
`else
      assign elig_vec[gi] = s.valid & (s.dbuffered >= n);
`endif

      // emit debit first, then credit on top, so a same-cycle hit gives old - n + add
      always_comb begin
         nx = s;
         if (emit && (sel_idx == IDX_W'(gi))) begin
            nx.remaining = s.remaining - n;
            nx.dbuffered = s.dbuffered - n;
`ifdef SRPT_DATA_GRANT_EN
            nx.granted   = s.granted - n;
`endif
            if (nx.remaining == '0) nx.valid = 1'b0;
         end
         if (credit_rd && hit_found && (hit_idx == IDX_W'(gi))) begin
            if (credit_is_grant) nx.granted   = sat_add32(nx.granted, credit_add);
            else                 nx.dbuffered = sat_add32(nx.dbuffered, credit_add);
         end
         if (sendmsg_in_read_en_o && (free_idx == IDX_W'(gi))) begin
            nx.valid     = 1'b1;
            nx.dbuff_id  = sendmsg_in_data_i[DBUFF_ID_HI:DBUFF_ID_LO];
            nx.remaining = sendmsg_in_data_i[REMAINING_HI:REMAINING_LO];
            nx.granted   = sendmsg_in_data_i[GRANTED_HI:GRANTED_LO];
            nx.dbuffered = sendmsg_in_data_i[DBUFFERED_HI:DBUFFERED_LO];
         end
      end

      assign slots_next[gi] = nx;
   end

   srpt_min_select #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_min_select (
      .remaining (rem_vec),
      .eligible  (elig_vec),
      .idx       (sel_idx),
      .found     (sel_found)
   );

   assign sel_slot = slots_reg[sel_idx];
   assign emit     = run & ap_continue & ~data_pkt_full_i & sel_found;

   always_comb begin
      data_pkt_data_o = '0;
      if (sel_found) begin
         data_pkt_data_o = {sel_slot.dbuffered, sel_slot.granted,
                            sel_slot.remaining, sel_slot.dbuff_id};
      end
   end

   assign data_pkt_write_en_o = emit;
   assign ap_done             = emit;
   assign ap_ready            = run;
   assign ap_idle             = ~any_valid & sendmsg_in_empty_i & dbuff_in_empty_i & grant_quiet;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < DEPTH; i++) slots_reg[i] <= '0;
      end else if (ap_ce) begin
         for (int i = 0; i < DEPTH; i++) slots_reg[i] <= slots_next[i];
      end
   end
endmodule

// File: tb/tb_srpt_data_pkt_queue.sv
// Randomized and directed bench for srpt_data_pkt_queue against a queue/array
// reference model of the SRPT scheduling rules.
module tb_srpt_data_pkt_queue;
   localparam int     DEPTH = 16;
   localparam longint PKT   = 1024;
   localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
`ifdef SRPT_DATA_GRANT_EN
   localparam bit GRANT_EN = 1'b1;
`else
   localparam bit GRANT_EN = 1'b0;
`endif

   logic         ap_clk = 1'b0;
   logic         ap_rst_n = 1'b0;
   logic         ap_ce = 1'b1, ap_start = 1'b1, ap_continue = 1'b1;
   logic         ap_idle, ap_done, ap_ready;
   logic         sendmsg_in_empty_i = 1'b1, sendmsg_in_read_en_o;
   logic [105:0] sendmsg_in_data_i = '0;
   logic         grant_in_empty_i = 1'b1, grant_in_read_en_o;
   logic [41:0]  grant_in_data_i = '0;
   logic         dbuff_in_empty_i = 1'b1, dbuff_in_read_en_o;
   logic [41:0]  dbuff_in_data_i = '0;
   logic         data_pkt_full_i = 1'b0, data_pkt_write_en_o;
   logic [105:0] data_pkt_data_o;

   srpt_data_pkt_queue #(.DEPTH(DEPTH), .PKT_SIZE(1024)) dut (
      .ap_clk               (ap_clk),
      .ap_rst_n             (ap_rst_n),
      .ap_ce                (ap_ce),
      .ap_start             (ap_start),
      .ap_continue          (ap_continue),
      .ap_idle              (ap_idle),
      .ap_done              (ap_done),
      .ap_ready             (ap_ready),
      .sendmsg_in_empty_i   (sendmsg_in_empty_i),
      .sendmsg_in_read_en_o (sendmsg_in_read_en_o),
      .sendmsg_in_data_i    (sendmsg_in_data_i),
      .grant_in_empty_i     (grant_in_empty_i),
      .grant_in_read_en_o   (grant_in_read_en_o),
      .grant_in_data_i      (grant_in_data_i),
      .dbuff_in_empty_i     (dbuff_in_empty_i),
      .dbuff_in_read_en_o   (dbuff_in_read_en_o),
      .dbuff_in_data_i      (dbuff_in_data_i),
      .data_pkt_full_i      (data_pkt_full_i),
      .data_pkt_write_en_o  (data_pkt_write_en_o),
      .data_pkt_data_o      (data_pkt_data_o)
   );

   always #5 ap_clk = ~ap_clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit ce = 1'b1, start = 1'b1, cont = 1'b1, full = 1'b0;
   logic [105:0] send_q[$];
   logic [41:0]  grant_q[$];
   logic [41:0]  dbuff_q[$];
   logic [105:0] wr_log[$];

   bit     m_valid [DEPTH];
   longint m_id    [DEPTH];
   longint m_rem   [DEPTH];
   longint m_gr    [DEPTH];
   longint m_db    [DEPTH];

   function automatic logic [105:0] pack_msg(input logic [9:0] id, input logic [31:0] rem,
                                             input logic [31:0] gr, input logic [31:0] db);
      return {db, gr, rem, id};
   endfunction

   function automatic logic [41:0] pack_credit(input logic [9:0] id, input logic [31:0] amt);
      return {amt, id};
   endfunction

   task automatic drive_inputs();
      ap_ce              = ce;
      ap_start           = start;
      ap_continue        = cont;
      data_pkt_full_i    = full;
      sendmsg_in_empty_i = (send_q.size() == 0);
      sendmsg_in_data_i  = sendmsg_in_empty_i ? '0 : send_q[0];
      grant_in_empty_i   = (grant_q.size() == 0);
      grant_in_data_i    = grant_in_empty_i ? '0 : grant_q[0];
      dbuff_in_empty_i   = (dbuff_q.size() == 0);
      dbuff_in_data_i    = dbuff_in_empty_i ? '0 : dbuff_q[0];
   endtask

   task automatic clear_model();
      send_q.delete();
      grant_q.delete();
      dbuff_q.delete();
      wr_log.delete();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      ce = 1'b1; start = 1'b1; cont = 1'b1; full = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      clear_model();
      drive_inputs();
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   // one clock: drive FIFO heads, compare every output with the model, then advance the model
   task automatic cycle();
      bit en, eg, ed, es, ew, idle;
      int best, hit, fr;
      longint n, amt, cid;
      logic [105:0] exp_data, w;
      logic [41:0] cw;
      @(negedge ap_clk);
      cyc++;
      drive_inputs();
      #1;
      en = ce && start;
      eg = GRANT_EN && en && (grant_q.size() > 0);
      ed = en && (dbuff_q.size() > 0) && !eg;
      fr = -1;
      for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && fr < 0) fr = i;
      es = en && (send_q.size() > 0) && !eg && !ed && (fr >= 0);
      best = -1;
      for (int i = 0; i < DEPTH; i++) begin
         n = (m_rem[i] < PKT) ? m_rem[i] : PKT;
         if (m_valid[i] && m_db[i] >= n && (!GRANT_EN || m_gr[i] >= n))
            if (best < 0 || m_rem[i] < m_rem[best]) best = i;
      end
      ew = en && cont && !full && (best >= 0);
      idle = (send_q.size() == 0) && (dbuff_q.size() == 0) && (!GRANT_EN || grant_q.size() == 0);
      for (int i = 0; i < DEPTH; i++) if (m_valid[i]) idle = 1'b0;

      n_tests++;
      if (data_pkt_write_en_o !== ew) begin
         n_fail++;
         $display("FAIL write_en cyc=%0d got=%b want=%b", cyc, data_pkt_write_en_o, ew);
      end
      if (ew) begin
         exp_data = {32'(m_db[best]), 32'(m_gr[best]), 32'(m_rem[best]), 10'(m_id[best])};
         n_tests++;
         if (data_pkt_data_o !== exp_data) begin
            n_fail++;
            $display("FAIL pkt_data cyc=%0d got=%h want=%h", cyc, data_pkt_data_o, exp_data);
         end
      end
      n_tests++;
      if ({grant_in_read_en_o, dbuff_in_read_en_o, sendmsg_in_read_en_o} !== {eg, ed, es}) begin
         n_fail++;
         $display("FAIL read_en cyc=%0d got(g,d,s)=%b%b%b want=%b%b%b", cyc, grant_in_read_en_o,
                  dbuff_in_read_en_o, sendmsg_in_read_en_o, eg, ed, es);
      end
      n_tests++;
      if ({ap_done, ap_ready, ap_idle} !== {ew, en, idle}) begin
         n_fail++;
         $display("FAIL ap_ctrl cyc=%0d got(done,ready,idle)=%b%b%b want=%b%b%b", cyc,
                  ap_done, ap_ready, ap_idle, ew, en, idle);
      end
      if (data_pkt_write_en_o === 1'b1) wr_log.push_back(data_pkt_data_o);

      hit = -1;
      cid = 0;
      amt = 0;
      if (eg || ed) begin
         cw  = eg ? grant_q[0] : dbuff_q[0];
         cid = 64'(cw[9:0]);
         amt = 64'(cw[41:10]);
         for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_id[i] == cid && hit < 0) hit = i;
      end
      n = 0;
      if (ew) begin
         n = (m_rem[best] < PKT) ? m_rem[best] : PKT;
         m_rem[best] -= n;
         m_db[best]  -= n;
         if (GRANT_EN) m_gr[best] -= n;
      end
      if (hit >= 0) begin
         if (eg) m_gr[hit] = (m_gr[hit] + amt > MAX32) ? MAX32 : m_gr[hit] + amt;
         else    m_db[hit] = (m_db[hit] + amt > MAX32) ? MAX32 : m_db[hit] + amt;
      end
      if (ew && m_rem[best] == 0) m_valid[best] = 1'b0;
      if (es) begin
         w = send_q[0];
         m_valid[fr] = 1'b1;
         m_id[fr]    = 64'(w[9:0]);
         m_rem[fr]   = 64'(w[41:10]);
         m_gr[fr]    = 64'(w[73:42]);
         m_db[fr]    = 64'(w[105:74]);
         void'(send_q.pop_front());
      end
      if (eg) void'(grant_q.pop_front());
      if (ed) void'(dbuff_q.pop_front());
      $display("[TB] cyc=%0d wr=%b data=%h rd(g,d,s)=%b%b%b", cyc, data_pkt_write_en_o,
               data_pkt_data_o, grant_in_read_en_o, dbuff_in_read_en_o, sendmsg_in_read_en_o);
   endtask

   function automatic logic [31:0] rem_of(input logic [105:0] w);
      return w[41:10];
   endfunction

   task automatic test_reset();
      clear_model();
      drive_inputs();
      ap_rst_n = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      n_tests++;
      if ({data_pkt_write_en_o, ap_done, grant_in_read_en_o, dbuff_in_read_en_o,
           sendmsg_in_read_en_o} !== 5'b0 || data_pkt_data_o !== '0 || ap_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state got wr=%b done=%b data=%h idle=%b want 0/0/0/1",
                  data_pkt_write_en_o, ap_done, data_pkt_data_o, ap_idle);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (3) cycle();
   endtask

   task automatic test_stall_resume();
      int exp_rem [4] = '{10000, 8976, 7952, 6928};
      logic [105:0] w;
      do_reset();
      send_q.push_back(pack_msg(10'd1, 32'd10000, 32'd5000, 32'd5000));
      repeat (12) cycle();
      n_tests++;
      if (wr_log.size() != 4) begin
         n_fail++;
         $display("FAIL stall_count got=%0d want=4", wr_log.size());
      end
      for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
         w = wr_log[k];
         n_tests++;
         if (rem_of(w) !== 32'(exp_rem[k])) begin
            n_fail++;
            $display("FAIL stall_rem%0d got=%0d want=%0d", k, rem_of(w), exp_rem[k]);
         end
      end
      wr_log.delete();
`ifdef SRPT_DATA_GRANT_EN
      grant_q.push_back(pack_credit(10'd1, 32'd5000));
`endif
      dbuff_q.push_back(pack_credit(10'd1, 32'd5000));
      repeat (12) cycle();
      n_tests++;
      if (wr_log.size() != 6) begin
         n_fail++;
         $display("FAIL resume_count got=%0d want=6", wr_log.size());
      end
      if (wr_log.size() > 0) begin
         w = wr_log[0];
         n_tests++;
         if (rem_of(w) !== 32'd5904 || w[105:74] !== 32'd5904) begin
            n_fail++;
            $display("FAIL resume_first got rem=%0d db=%0d want 5904/5904", rem_of(w), w[105:74]);
         end
         w = wr_log[wr_log.size() - 1];
         n_tests++;
         if (rem_of(w) !== 32'd784) begin
            n_fail++;
            $display("FAIL resume_last got rem=%0d want=784", rem_of(w));
         end
      end
      n_tests++;
      if (ap_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_after_drain got=%b want=1", ap_idle);
      end
   endtask

   task automatic test_srpt_order();
      int ids [4] = '{4, 3, 1, 2};
      logic [105:0] w;
      do_reset();
      full = 1'b1;
      for (int k = 0; k < 4; k++)
         send_q.push_back(pack_msg(10'(ids[k]), 32'(ids[k]), 32'd100, 32'd100));
      repeat (6) cycle();
      full = 1'b0;
      repeat (6) cycle();
      n_tests++;
      if (wr_log.size() != 4) begin
         n_fail++;
         $display("FAIL order_count got=%0d want=4", wr_log.size());
      end
      for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
         w = wr_log[k];
         n_tests++;
         if (w[9:0] !== 10'(k + 1) || rem_of(w) !== 32'(k + 1)) begin
            n_fail++;
            $display("FAIL order_pos%0d got id=%0d rem=%0d want %0d", k, w[9:0], rem_of(w), k + 1);
         end
      end
   endtask

   task automatic test_full_stall();
      logic [105:0] w;
      do_reset();
      full = 1'b1;
      send_q.push_back(pack_msg(10'd7, 32'd3000, 32'd3000, 32'd3000));
      repeat (3) cycle();
      wr_log.delete();
      repeat (10) cycle();
      n_tests++;
      if (wr_log.size() != 0) begin
         n_fail++;
         $display("FAIL full_writes got=%0d want=0", wr_log.size());
      end
      full = 1'b0;
      repeat (2) cycle();
      n_tests++;
      w = (wr_log.size() > 0) ? wr_log[0] : '0;
      if (w !== pack_msg(10'd7, 32'd3000, 32'd3000, 32'd3000)) begin
         n_fail++;
         $display("FAIL full_release got=%h want=%h", w, pack_msg(10'd7, 32'd3000, 32'd3000, 32'd3000));
      end
   endtask

   task automatic test_fill();
      logic [105:0] w;
      do_reset();
      for (int k = 0; k <= DEPTH; k++)
         send_q.push_back(pack_msg(10'(20 + k), 32'd100, 32'd100, 32'd0));
      repeat (DEPTH + 6) cycle();
      n_tests++;
      if (send_q.size() != 1 || sendmsg_in_read_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_block got pending=%0d rd=%b want 1/0", send_q.size(), sendmsg_in_read_en_o);
      end
      dbuff_q.push_back(pack_credit(10'd20, 32'd100));
      repeat (6) cycle();
      n_tests++;
      w = (wr_log.size() > 0) ? wr_log[0] : '0;
      if (send_q.size() != 0 || wr_log.size() != 1 || w !== pack_msg(10'd20, 32'd100, 32'd100, 32'd100)) begin
         n_fail++;
         $display("FAIL fill_free got pending=%0d writes=%0d first=%h want 0/1/%h", send_q.size(),
                  wr_log.size(), w, pack_msg(10'd20, 32'd100, 32'd100, 32'd100));
      end
   endtask

   task automatic test_unknown_id();
      logic [105:0] w;
      do_reset();
      send_q.push_back(pack_msg(10'd5, 32'd200, 32'd200, 32'd0));
      repeat (2) cycle();
`ifdef SRPT_DATA_GRANT_EN
      grant_q.push_back(pack_credit(10'd99, 32'd500));
`else
      dbuff_q.push_back(pack_credit(10'd99, 32'd500));
`endif
      repeat (3) cycle();
      n_tests++;
      if (grant_q.size() != 0 || dbuff_q.size() != 0 || wr_log.size() != 0) begin
         n_fail++;
         $display("FAIL unknown_drop got pending=%0d writes=%0d want 0/0",
                  grant_q.size() + dbuff_q.size(), wr_log.size());
      end
      dbuff_q.push_back(pack_credit(10'd5, 32'd200));
      repeat (3) cycle();
      n_tests++;
      w = (wr_log.size() > 0) ? wr_log[0] : '0;
      if (wr_log.size() != 1 || w !== pack_msg(10'd5, 32'd200, 32'd200, 32'd200)) begin
         n_fail++;
         $display("FAIL unknown_nochange got writes=%0d first=%h want 1/%h", wr_log.size(), w,
                  pack_msg(10'd5, 32'd200, 32'd200, 32'd200));
      end
   endtask

   task automatic test_random();
      logic [31:0] amt;
      do_reset();
      for (int t = 0; t < 1500; t++) begin
         ce    = ($urandom_range(0, 7) != 0);
         start = ($urandom_range(0, 7) != 0);
         cont  = ($urandom_range(0, 7) != 0);
         full  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0 && send_q.size() < 2)
            send_q.push_back(pack_msg(10'($urandom_range(0, 5)), 32'($urandom_range(0, 4000)),
                                      32'($urandom_range(0, 3000)), 32'($urandom_range(0, 3000))));
         amt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FF00 : 32'($urandom_range(0, 2000));
         if ($urandom_range(0, 2) == 0 && dbuff_q.size() < 3)
            dbuff_q.push_back(pack_credit(10'($urandom_range(0, 6)), amt));
`ifdef SRPT_DATA_GRANT_EN
         amt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FF00 : 32'($urandom_range(0, 2000));
         if ($urandom_range(0, 2) == 0 && grant_q.size() < 3)
            grant_q.push_back(pack_credit(10'($urandom_range(0, 6)), amt));
`endif
         cycle();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_q.push_back(pack_msg(10'd3, 32'd50000, 32'd50000, 32'd50000));
      repeat (5) cycle();
      @(posedge ap_clk);
      #2;
      n_tests++;
      if (data_pkt_write_en_o !== 1'b1) begin
         n_fail++;
         $display("FAIL prereset_write got=%b want=1", data_pkt_write_en_o);
      end
      ap_rst_n = 1'b0;
      #1;
      n_tests++;
      if (data_pkt_write_en_o !== 1'b0 || data_pkt_data_o !== '0 || ap_idle !== 1'b1 ||
          {grant_in_read_en_o, dbuff_in_read_en_o, sendmsg_in_read_en_o} !== 3'b0) begin
         n_fail++;
         $display("FAIL async_reset got wr=%b data=%h idle=%b want 0/0/1",
                  data_pkt_write_en_o, data_pkt_data_o, ap_idle);
      end
      clear_model();
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (3) cycle();
   endtask

   initial begin
      test_reset();
      test_stall_resume();
      test_srpt_order();
      test_full_stall();
      test_fill();
      test_unknown_id();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout after %0d cycles", cyc);
      $fatal(1, "timeout");
   end
endmodule
